// File: rtl/life_pkg.sv
// life_pkg: state encodings, board cell indexing and B3/S23 rule constants
package life_pkg;
    typedef enum logic [1:0] {ST_EDIT = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10} state_t;
    localparam logic [3:0] LIFE_BIRTH      = 4'd3;
    localparam logic [3:0] LIFE_SURVIVE_LO = 4'd2;
    localparam logic [3:0] LIFE_SURVIVE_HI = 4'd3;
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction
endpackage

// File: rtl/life_next_gen.sv
// life_next_gen: combinational B3/S23 step of a ROWS x COLS board
// TORUS=1 wraps the edges; TORUS=0 treats cells beyond the edges as dead.
module life_next_gen
    import life_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int TORUS = 1
)(
    input  logic [ROWS*COLS-1:0] i_board,
    output logic [ROWS*COLS-1:0] o_board
);
    function automatic logic cell_at(input logic [ROWS*COLS-1:0] b, input int r, input int c);
        int rr;
        int cc;
        rr = (TORUS != 0) ? (r + ROWS) % ROWS : r;
        cc = (TORUS != 0) ? (c + COLS) % COLS : c;
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
        return b[cell_idx(rr, cc, COLS)];
    endfunction

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] w_n;
            always_comb begin
                w_n = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) w_n = w_n + 4'(cell_at(i_board, r + dr, c + dc));
            end
            assign o_board[cell_idx(r, c, COLS)] = (w_n == LIFE_BIRTH) ||
                (i_board[cell_idx(r, c, COLS)] && w_n >= LIFE_SURVIVE_LO && w_n <= LIFE_SURVIVE_HI);
        end
    end
endmodule

// File: rtl/life_sim_controller.sv
// life_sim_controller: Game of Life board with EDIT/RUN/PAUSE control and generation counter.
// Optional LIFE_STABLE_DETECT_EN: pause and flag stable_o when a RUN tick leaves the board unchanged.
module life_sim_controller
    import life_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_DIV = 33554432,
    parameter int GEN_W    = 16,
    parameter int TORUS    = 1,
    localparam int CW = $clog2(ROWS),
    localparam int TW = $clog2(TICK_DIV),
    localparam int N  = ROWS * COLS
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_clr,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_load,
    input  logic [COLS-1:0]  row_data,
    output logic [N-1:0]     board_o,
    output logic [GEN_W-1:0] gen_cnt_o,
    output logic [1:0]       state_o,
    output logic [CW-1:0]    cursor_o,
    output logic             stable_o
);
    logic [4:0]       r_sync1, r_sync2, r_prev, w_btn, w_stb;
    state_t           r_state, w_state_nx;
    logic [TW-1:0]    r_tick;
    logic [N-1:0]     r_board, w_next;
    logic [GEN_W-1:0] r_gen;
    logic [CW-1:0]    r_cursor, w_cur_up, w_cur_dn;
    logic             w_edit, w_clr, w_run, w_ed, w_tick, w_hit;

    // strobe bits: 0 run, 1 clr, 2 up, 3 dn, 4 load
    assign w_btn    = {btn_load, btn_dn, btn_up, btn_clr, btn_run};
    assign w_stb    = r_sync2 & ~r_prev;
    assign w_edit   = r_state != ST_RUN;
    assign w_clr    = w_stb[1] & w_edit;
    assign w_run    = w_stb[0] & ~w_clr;
    assign w_ed     = w_edit & ~w_clr & ~w_run;
    assign w_tick   = r_state == ST_RUN && r_tick == TW'(TICK_DIV - 1);
    assign w_cur_up = (r_cursor == '0) ? CW'(ROWS - 1) : r_cursor - 1'b1;
    assign w_cur_dn = (r_cursor == CW'(ROWS - 1)) ? '0 : r_cursor + 1'b1;

    life_next_gen #(.ROWS(ROWS), .COLS(COLS), .TORUS(TORUS)) u_next (
        .i_board(r_board),
        .o_board(w_next)
    );

    always_comb begin
        w_state_nx = r_state;
        if (w_run) w_state_nx = w_edit ? ST_RUN : ST_PAUSE;
        if (w_hit) w_state_nx = ST_PAUSE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= ST_EDIT;
        else r_state <= w_state_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_tick   <= '0;
            r_board  <= '0;
            r_gen    <= '0;
            r_cursor <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= (w_edit || w_run || w_tick) ? '0 : r_tick + 1'b1;
            if (w_clr) begin
                r_board <= '0;
                r_gen   <= '0;
            end else if (w_tick && !w_hit) begin
                r_board <= w_next;
                r_gen   <= r_gen + 1'b1;
            end else if (w_ed && w_stb[4]) begin
                r_board[cell_idx(int'(r_cursor), 0, COLS) +: COLS] <= row_data;
            end
            // load above uses the pre-move cursor
            if (w_ed && (w_stb[2] ^ w_stb[3])) r_cursor <= w_stb[2] ? w_cur_up : w_cur_dn;
        end
    end

`ifdef LIFE_STABLE_DETECT_EN
    logic r_stable;
    assign w_hit = w_tick && (w_next == r_board);
    always_ff @(posedge clk or posedge reset)
        if (reset) r_stable <= 1'b0;
        else if (w_hit) r_stable <= 1'b1;
        else if (w_clr || (w_ed && w_stb[4]) || (w_run && w_edit)) r_stable <= 1'b0;
    assign stable_o = r_stable;
`else
    assign w_hit    = 1'b0;
    assign stable_o = 1'b0;
`endif

    assign board_o   = r_board;
    assign gen_cnt_o = r_gen;
    assign state_o   = r_state;
    assign cursor_o  = r_cursor;
endmodule

// File: tb/tb_life_sim_controller.sv
// tb_life_sim_controller: behavioural-model bench for life_sim_controller on an 8x8 board.
// Honours LIFE_STABLE_DETECT_EN when defined.
module tb_life_sim_controller;
    localparam int TD = 4;
`ifdef LIFE_STABLE_DETECT_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b0;
    logic [4:0]  btns = '0;
    logic [7:0]  row_data = '0;
    logic [63:0] board_o, board0;
    logic [3:0]  gen_cnt_o, gen0;
    logic [1:0]  state_o, state0;
    logic [2:0]  cursor_o, cursor0;
    logic        stable_o, stable0;
    int          n_chk = 0, n_fail = 0;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    life_sim_controller #(.ROWS(8), .COLS(8), .TICK_DIV(TD), .GEN_W(4), .TORUS(1)) dut (
        .clk(clk), .reset(reset), .btn_run(btns[0]), .btn_clr(btns[1]), .btn_up(btns[2]),
        .btn_dn(btns[3]), .btn_load(btns[4]), .row_data(row_data), .board_o(board_o),
        .gen_cnt_o(gen_cnt_o), .state_o(state_o), .cursor_o(cursor_o), .stable_o(stable_o)
    );

    life_sim_controller #(.ROWS(8), .COLS(8), .TICK_DIV(TD), .GEN_W(4), .TORUS(0)) dut0 (
        .clk(clk), .reset(reset), .btn_run(btns[0]), .btn_clr(btns[1]), .btn_up(btns[2]),
        .btn_dn(btns[3]), .btn_load(btns[4]), .row_data(row_data), .board_o(board0),
        .gen_cnt_o(gen0), .state_o(state0), .cursor_o(cursor0), .stable_o(stable0)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // toroidal 8x8 B3/S23 step over a flat board (bit r*8+c)
    function automatic logic [63:0] life(input logic [63:0] b);
        logic [63:0] nb;
        int n;
        nb = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(b[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
                nb[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
            end
        return nb;
    endfunction

    logic [63:0] mb;
    int          mgen, mst, mcur, mtc;
    bit          mstab;
    logic [4:0]  h1, h2, h3;

    // model: pin level two edges back high and three back low acts on this edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mb = '0; mgen = 0; mst = 0; mcur = 0; mtc = 0; mstab = 1'b0;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            logic [4:0]  s;
            logic [63:0] nb;
            bit          tick, edit;
            s = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = btns;
            edit = mst != 1;
            tick = !edit && mtc == TD - 1;
            mtc = edit ? 0 : (mtc + 1) % TD;
            if (edit && s[1]) begin
                mb = '0; mgen = 0; mstab = 1'b0;
            end else begin
                if (tick) begin
                    nb = life(mb);
                    if (STAB && nb == mb) begin mst = 2; mstab = 1'b1; end
                    else begin mb = nb; mgen = (mgen + 1) % 16; end
                end
                if (s[0]) begin
                    mst = edit ? 1 : 2;
                    if (edit) mstab = 1'b0;
                end else if (edit) begin
                    if (s[4]) begin mb[mcur * 8 +: 8] = row_data; mstab = 1'b0; end
                    if (s[2] && !s[3]) mcur = (mcur + 7) % 8;
                    if (s[3] && !s[2]) mcur = (mcur + 1) % 8;
                end
            end
        end
    end

    always @(negedge clk)
        if (cmp_en && !reset) begin
            chk("board", board_o, mb);
            chk("gen", 64'(gen_cnt_o), 64'(mgen));
            chk("state", 64'(state_o), 64'(mst));
            chk("cursor", 64'(cursor_o), 64'(mcur));
            chk("stable", 64'(stable_o), 64'(mstab));
        end

    task automatic press(input int b);
        @(negedge clk);
        btns[b] = 1'b1;
        @(negedge clk);
        btns[b] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_gen(input int g);
        int i = 0;
        while (int'(gen_cnt_o) != g && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("wait_gen", 64'(gen_cnt_o), 64'(g));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_board"}, board_o, 64'h0);
        chk({nm, "_gen"}, 64'(gen_cnt_o), 64'h0);
        chk({nm, "_state"}, 64'(state_o), 64'h0);
        chk({nm, "_cursor"}, 64'(cursor_o), 64'h0);
        chk({nm, "_stable"}, 64'(stable_o), 64'h0);
    endtask

    initial begin
        int cnt, i;
        logic [3:0] pg;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;
        cmp_en = 1'b1;

        // blinker in row 3
        repeat (3) press(3);
        chk("t1_cursor", 64'(cursor_o), 64'd3);
        row_data = 8'h1C;
        press(4);
        chk("t1_load", board_o, 64'h0000_0000_1C00_0000);
        press(0);
        wait_gen(1);
        chk("t1_gen1_board", board_o, 64'h0000_0008_0808_0000);
        wait_gen(2);
        chk("t1_gen2_board", board_o, 64'h0000_0000_1C00_0000);

        // clr/load ignored in RUN, then pause, clear and wrap the cursor
        press(1);
        chk("t4_clr_in_run", 64'(state_o), 64'd1);
        row_data = 8'hFF;
        press(4);
        press(0);
        chk("t4_pause", 64'(state_o), 64'd2);
        press(1);
        chk("t4_clr_board", board_o, 64'h0);
        chk("t4_clr_gen", 64'(gen_cnt_o), 64'h0);
        repeat (3) press(2);
        chk("t4_cursor0", 64'(cursor_o), 64'd0);
        press(2);
        chk("t4_cursor_wrap", 64'(cursor_o), 64'd7);

        // asynchronous reset mid-RUN
        press(0);
        chk("t5_run", 64'(state_o), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset("t5_async");
        @(posedge clk);
        #2 reset = 1'b0;

        // glider, 32 generations on the torus
        row_data = 8'h02; press(4); press(3);
        row_data = 8'h04; press(4); press(3);
        row_data = 8'h07; press(4);
        chk("t2_load", board_o, 64'h0000_0000_0007_0402);
        press(0);
        cnt = 0; i = 0; pg = gen_cnt_o;
        while (cnt < 32 && i < 200) begin
            @(negedge clk);
            i++;
            if (gen_cnt_o != pg) begin
                cnt++;
                pg = gen_cnt_o;
                if (cnt == 16) chk("t2_gen_wrap16", 64'(gen_cnt_o), 64'h0);
            end
        end
        chk("t2_ticks", 64'(cnt), 64'd32);
        chk("t2_board", board_o, 64'h0000_0000_0007_0402);
        chk("t2_gen", 64'(gen_cnt_o), 64'h0);

        // corner cells: block on the torus, isolated cells without wrap
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        row_data = 8'h81; press(4); press(2); press(4);
        chk("t3_load", board_o, 64'h8100_0000_0000_0081);
        chk("t3_load0", board0, 64'h8100_0000_0000_0081);
        press(0);
        i = 0;
        while (gen0 != 4'd1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("t3_gen0", 64'(gen0), 64'd1);
        chk("t3_board0", board0, 64'h0);
        chk("t6_board", board_o, 64'h8100_0000_0000_0081);
`ifdef LIFE_STABLE_DETECT_EN
        chk("t6_state", 64'(state_o), 64'd2);
        chk("t6_stable", 64'(stable_o), 64'd1);
        chk("t6_gen", 64'(gen_cnt_o), 64'd0);
`else
        chk("t6_state", 64'(state_o), 64'd1);
        chk("t6_stable", 64'(stable_o), 64'd0);
        chk("t6_gen", 64'(gen_cnt_o), 64'd1);
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
